cr_osf_ob_arb: RTL and testbench

CR_OSF_OB_ARB -- requirements
Module: cr_osf_ob_arb

---
 rtl/cr_osf_ob_arb_if.sv | 29 ++
 rtl/cr_osf_ob_arb.sv | 123 ++++++++++++
 tb/tb_cr_osf_ob_arb.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_osf_ob_arb_if.sv
// Bus bundle between the outbound arbiter, its two source FIFOs and the outbound FIFO.
// The arbiter connects through the master modport; the FIFO side connects through slave.
interface cr_osf_ob_arb_if;
    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic [1:0]  tuser;   // [0]=sot, [1]=eot
    } axi4s_dp_bus_t;

    axi4s_dp_bus_t src0_rdata;
    logic          src0_empty;
    logic          src0_rd;
    axi4s_dp_bus_t src1_rdata;
    logic          src1_empty;
    logic          src1_rd;
    logic          ob_fifo_full;
    logic          ob_fifo_wr;
    axi4s_dp_bus_t ob_fifo_wdata;

    modport master (
        input  src0_rdata, src0_empty, src1_rdata, src1_empty, ob_fifo_full,
        output src0_rd, src1_rd, ob_fifo_wr, ob_fifo_wdata
    );

    modport slave (
        output src0_rdata, src0_empty, src1_rdata, src1_empty, ob_fifo_full,
        input  src0_rd, src1_rd, ob_fifo_wr, ob_fifo_wdata
    );
endinterface

// File: rtl/cr_osf_ob_arb.sv
// Two-source frame-granular round-robin arbiter into the outbound FIFO, with per-grant quantum.
// Optional per-source completed-frame counters are compiled in with CR_OSF_OB_ARB_STATS_EN.
module cr_osf_ob_arb #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    cr_osf_ob_arb_if.master    bus,
    input  logic [3:0]         quantum,
    input  logic               arb_hold
`ifdef CR_OSF_OB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   src0_frm_cnt,
    output logic [CNT_W-1:0]   src1_frm_cnt
`endif
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_t;

    arb_state_t state;
    logic       rr_ptr;
    logic [3:0] frm_q;
    logic [3:0] quantum_q;
    logic       in_frm;

    logic xfer0;
    logic xfer1;
    logic xfer;
    logic eot;
    logic cur_empty;
    logic oth_empty;
    logic quota_done;

    function automatic logic [3:0] eff_quantum(input logic [3:0] q);
        return (q == 4'd0) ? 4'd1 : q;
    endfunction

    // Strobes are gated by rst_n so nothing is popped or pushed while reset is asserted.
    assign xfer0 = rst_n && (state == ARB_G0) && !bus.src0_empty && !bus.ob_fifo_full;
    assign xfer1 = rst_n && (state == ARB_G1) && !bus.src1_empty && !bus.ob_fifo_full;
    assign xfer  = xfer0 | xfer1;

    assign bus.src0_rd       = xfer0;
    assign bus.src1_rd       = xfer1;
    assign bus.ob_fifo_wr    = xfer;
    assign bus.ob_fifo_wdata = (state == ARB_G1) ? bus.src1_rdata : bus.src0_rdata;

    assign eot        = xfer && bus.ob_fifo_wdata.tuser[1];
    assign cur_empty  = (state == ARB_G1) ? bus.src1_empty : bus.src0_empty;
    assign oth_empty  = (state == ARB_G1) ? bus.src0_empty : bus.src1_empty;
    assign quota_done = ({1'b0, frm_q} + 5'd1) >= {1'b0, quantum_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= 1'b0;
            frm_q     <= 4'd0;
            quantum_q <= 4'd1;
            in_frm    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (!arb_hold) begin
                        if (!bus.src0_empty && (bus.src1_empty || !rr_ptr)) begin
                            state     <= ARB_G0;
                            frm_q     <= 4'd0;
                            quantum_q <= eff_quantum(quantum);
                            in_frm    <= 1'b0;
                        end else if (!bus.src1_empty) begin
                            state     <= ARB_G1;
                            frm_q     <= 4'd0;
                            quantum_q <= eff_quantum(quantum);
                            in_frm    <= 1'b0;
                        end
                    end
                end
                ARB_G0, ARB_G1: begin
                    if (eot) begin
                        rr_ptr <= (state == ARB_G0);
                        in_frm <= 1'b0;
                        if (quota_done && !oth_empty && !arb_hold) begin
                            state     <= (state == ARB_G0) ? ARB_G1 : ARB_G0;
                            frm_q     <= 4'd0;
                            quantum_q <= eff_quantum(quantum);
                        end else if (!cur_empty && !arb_hold) begin
                            frm_q <= frm_q + 4'd1;
                        end else begin
                            state <= ARB_IDLE;
                            frm_q <= frm_q + 4'd1;
                        end
                    end else if (xfer) begin
                        in_frm <= 1'b1;
                    end else if (!in_frm && (cur_empty || arb_hold)) begin
                        // Between frames with nothing to send: release so IDLE can re-arbitrate.
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef CR_OSF_OB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src0_frm_cnt <= '0;
            src1_frm_cnt <= '0;
        end else begin
            if (eot && xfer0) src0_frm_cnt <= src0_frm_cnt + CNT_W'(1);
            if (eot && xfer1) src1_frm_cnt <= src1_frm_cnt + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the statistics counters, which are absent in this build.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_cr_osf_ob_arb.sv
// Directed scoreboard bench for cr_osf_ob_arb: source FIFO models, expected-word queue,
// immediate assertions on every outbound write and on the idle/hold/full/reset windows.
module tb_cr_osf_ob_arb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] quantum = 4'd1;
    logic       arb_hold = 1'b0;
    logic       ob_full = 1'b0;

    always #5 clk = ~clk;

    cr_osf_ob_arb_if ifc();

`ifdef CR_OSF_OB_ARB_STATS_EN
    logic [3:0] src0_frm_cnt;
    logic [3:0] src1_frm_cnt;
`endif

    cr_osf_ob_arb #(.CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifc),
        .quantum  (quantum),
        .arb_hold (arb_hold)
`ifdef CR_OSF_OB_ARB_STATS_EN
        ,
        .src0_frm_cnt (src0_frm_cnt),
        .src1_frm_cnt (src1_frm_cnt)
`endif
    );

    // Entries are {tuser[1:0], tdata[63:0]}.
    logic [65:0] q0[$];
    logic [65:0] q1[$];
    logic [65:0] exp_q[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nwr = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    logic       wr_seen;
    logic [1:0] rd_seen;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] mk_word(input int src, input int frm, input int w, input int n);
        logic [63:0] d;
        logic [1:0]  u;
        d = {16'hC0DE, 16'(src), 16'(frm), 16'(w)};
        u = {(w == n - 1), (w == 0)};
        return {u, d};
    endfunction

    task automatic load_frame(input int src, input int frm, input int n);
        for (int w = 0; w < n; w++) begin
            if (src == 0) q0.push_back(mk_word(src, frm, w, n));
            else          q1.push_back(mk_word(src, frm, w, n));
        end
    endtask

    task automatic expect_frame(input int src, input int frm, input int n);
        for (int w = 0; w < n; w++) exp_q.push_back(mk_word(src, frm, w, n));
    endtask

    task automatic drive();
        logic [65:0] h0;
        logic [65:0] h1;
        h0 = (q0.size() != 0) ? q0[0] : '0;
        h1 = (q1.size() != 0) ? q1[0] : '0;
        ifc.src0_empty       = (q0.size() == 0);
        ifc.src0_rdata.tdata = h0[63:0];
        ifc.src0_rdata.tkeep = 8'hFF;
        ifc.src0_rdata.tuser = h0[65:64];
        ifc.src1_empty       = (q1.size() == 0);
        ifc.src1_rdata.tdata = h1[63:0];
        ifc.src1_rdata.tkeep = 8'hFF;
        ifc.src1_rdata.tuser = h1[65:64];
        ifc.ob_fifo_full     = ob_full;
    endtask

    // One clock: apply inputs, observe mid-cycle, retire popped words, advance past the edge.
    task automatic step();
        logic [65:0] got;
        drive();
        @(negedge clk);
        wr_seen = ifc.ob_fifo_wr;
        rd_seen = {ifc.src1_rd, ifc.src0_rd};
        if (wr_seen) begin
            chk("rd_one_hot_on_wr", 66'(rd_seen == 2'b01 || rd_seen == 2'b10), 66'd1);
            got = {ifc.ob_fifo_wdata.tuser, ifc.ob_fifo_wdata.tdata};
            chk("sb_has_entry", 66'(exp_q.size() != 0), 66'd1);
            if (exp_q.size() != 0) chk("wdata_order", got, exp_q.pop_front());
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            nwr++;
        end else begin
            chk("rd_without_wr", 66'(rd_seen), 66'd0);
        end
        if (rd_seen[0] && q0.size() != 0) void'(q0.pop_front());
        if (rd_seen[1] && q1.size() != 0) void'(q1.pop_front());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 66'(exp_q.size() == 0), 66'd1);
    endtask

    task automatic run_writes(input string tag, input int k, input int budget);
        int target;
        int n;
        target = nwr + k;
        n = 0;
        while (nwr < target && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_progress"}, 66'(nwr >= target), 66'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both sources already loaded: nothing may move.
        load_frame(0, 0, 3); load_frame(0, 1, 3);
        load_frame(1, 0, 3); load_frame(1, 1, 3);
        expect_frame(0, 0, 3); expect_frame(1, 0, 3);
        expect_frame(0, 1, 3); expect_frame(1, 1, 3);
        repeat (2) begin
            step();
            chk("rst_no_wr", 66'(wr_seen), 66'd0);
            chk("rst_no_rd", 66'(rd_seen), 66'd0);
        end
        rst_n = 1'b1;
        step();
        chk("idle_after_rst_no_wr", 66'(wr_seen), 66'd0);

        // quantum=1 alternation, 12 back-to-back writes.
        first_cyc = -1;
        nwr = 0;
        drain("t1", 40);
        chk("t1_write_count", 66'(nwr), 66'd12);
        chk("t1_no_gaps", 66'(last_cyc - first_cyc), 66'd11);
        repeat (3) step();

        // quantum=2: two frames per grant.
        quantum = 4'd2;
        for (int f = 0; f < 4; f++) begin
            load_frame(0, 8'h10 + f, 2);
            load_frame(1, 8'h10 + f, 2);
        end
        expect_frame(0, 8'h10, 2); expect_frame(0, 8'h11, 2);
        expect_frame(1, 8'h10, 2); expect_frame(1, 8'h11, 2);
        expect_frame(0, 8'h12, 2); expect_frame(0, 8'h13, 2);
        expect_frame(1, 8'h12, 2); expect_frame(1, 8'h13, 2);
        drain("t2", 60);
        repeat (3) step();

        // quantum=0 behaves as 1; outbound full for 5 cycles mid-frame.
        quantum = 4'd0;
        load_frame(0, 8'h20, 6); load_frame(0, 8'h21, 2);
        expect_frame(0, 8'h20, 6); expect_frame(1, 8'h22, 3); expect_frame(0, 8'h21, 2);
        run_writes("t3_pre", 2, 10);
        load_frame(1, 8'h22, 3);
        ob_full = 1'b1;
        repeat (5) begin
            step();
            chk("t3_full_no_wr", 66'(wr_seen), 66'd0);
            chk("t3_full_no_rd", 66'(rd_seen), 66'd0);
        end
        ob_full = 1'b0;
        drain("t3", 40);
        repeat (3) step();

        // arb_hold raised at word 2 of a 4-word src0 frame.
        quantum = 4'd1;
        load_frame(0, 8'h30, 4); load_frame(0, 8'h31, 2);
        expect_frame(0, 8'h30, 4); expect_frame(1, 8'h32, 3); expect_frame(0, 8'h31, 2);
        run_writes("t4_pre", 1, 10);
        arb_hold = 1'b1;
        load_frame(1, 8'h32, 3);
        run_writes("t4_finish_frame", 3, 10);
        repeat (5) begin
            step();
            chk("t4_hold_no_wr", 66'(wr_seen), 66'd0);
        end
        arb_hold = 1'b0;
        drain("t4", 40);
        repeat (3) step();

        // One-cycle reset in the middle of a src0 frame; FIFOs flushed alongside.
        load_frame(0, 8'h40, 5);
        expect_frame(0, 8'h40, 5);
        run_writes("t5_pre", 2, 10);
        rst_n = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        load_frame(0, 8'h41, 3);
        expect_frame(0, 8'h41, 3);
        step();
        chk("t5_in_rst_no_wr", 66'(wr_seen), 66'd0);
        rst_n = 1'b1;
        step();
        chk("t5_after_rst_no_wr", 66'(wr_seen), 66'd0);
        chk("t5_after_rst_no_rd", 66'(rd_seen), 66'd0);
        drain("t5", 20);
        repeat (3) step();

`ifdef CR_OSF_OB_ARB_STATS_EN
        // 17 single-word src0 frames wrap a 4-bit counter to 1.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int f = 0; f < 17; f++) begin
            load_frame(0, 8'h50 + f, 1);
            expect_frame(0, 8'h50 + f, 1);
        end
        drain("t6", 60);
        chk("t6_src0_frm_cnt", 66'(src0_frm_cnt), 66'd1);
        chk("t6_src1_frm_cnt", 66'(src1_frm_cnt), 66'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
